// File: rtl/lut_cfg_writer.sv
// Configuration-frame writer for the L_FRAG array: parses SOF/N/data/checksum byte frames into a
// shadow buffer and commits the first N fragment truth tables atomically on a good checksum.
module lut_cfg_writer #(
    parameter int unsigned NUM_FRAGS = 8,
    parameter logic [7:0]  SOF_BYTE  = 8'hA5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             cfgData,
    input  logic                   cfgValid,
    output logic                   cfgReady,
    input  logic                   cfgAbort,
    output logic                   cfgBusy,
    output logic                   cfgDone,
    output logic                   cfgErr,
    output logic [16*NUM_FRAGS-1:0] fragBitInfoAll
);

    localparam int unsigned FW = 16 * NUM_FRAGS;
    localparam int unsigned CW = $clog2(2 * NUM_FRAGS) + 1;
    localparam int unsigned IW = CW - 1;
    localparam int unsigned NW = $clog2(NUM_FRAGS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM,
        S_COMMIT
    } state_e;

    state_e          state_q, state_d;
    logic [NW-1:0]   n_q, n_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      csum_q, csum_d;
    logic [FW-1:0]   shadow_q, shadow_d;
    logic [FW-1:0]   frag_q, frag_d;
    logic            ready_q, busy_q, done_q, err_q, err_d;
    logic            take_c;
    logic [CW-1:0]   cnt_last_c;

    assign take_c     = cfgValid && ready_q;
    assign cnt_last_c = CW'({n_q, 1'b0}) - CW'(1);

    // State and datapath registers; status outputs follow the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            cnt_q    <= '0;
            csum_q   <= '0;
            shadow_q <= '0;
            frag_q   <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            csum_q   <= csum_d;
            shadow_q <= shadow_d;
            frag_q   <= frag_d;
            ready_q  <= (state_d != S_COMMIT);
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_q == S_COMMIT);
            err_q    <= err_d;
        end
    end

    // Next-state and datapath update; abort wins over data everywhere except COMMIT
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        csum_d   = csum_q;
        shadow_d = shadow_q;
        frag_d   = frag_q;
        err_d    = 1'b0;

        if (cfgAbort && (state_q != S_COMMIT)) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (take_c && (cfgData == SOF_BYTE)) state_d = S_HDR;
                end
                S_HDR: begin
                    if (take_c) begin
                        if ((cfgData != 8'd0) && (cfgData <= 8'(NUM_FRAGS))) begin
                            n_d     = NW'(cfgData);
                            cnt_d   = '0;
                            csum_d  = cfgData;
                            state_d = S_DATA;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (take_c) begin
                        for (int unsigned i = 0; i < NUM_FRAGS; i++) begin
                            if (cnt_q[CW-1:1] == IW'(i)) begin
                                if (cnt_q[0]) shadow_d[16*i+8 +: 8] = cfgData;
                                else          shadow_d[16*i   +: 8] = cfgData;
                            end
                        end
                        csum_d = csum_q ^ cfgData;
                        cnt_d  = cnt_q + CW'(1);
                        if (cnt_q == cnt_last_c) state_d = S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (take_c) begin
                        if (cfgData == csum_q) begin
                            state_d = S_COMMIT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                S_COMMIT: begin
                    for (int unsigned i = 0; i < NUM_FRAGS; i++) begin
                        if (NW'(i) < n_q) frag_d[16*i +: 16] = shadow_q[16*i +: 16];
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign cfgReady       = ready_q;
    assign cfgBusy        = busy_q;
    assign cfgDone        = done_q;
    assign cfgErr         = err_q;
    assign fragBitInfoAll = frag_q;

endmodule
